// File: rtl/intr_dispatch_pkg.sv
// intr_dispatch_pkg: shared state encoding, group codes and field widths for the interrupt dispatcher.
package intr_dispatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_e;
  localparam int GRP_W = 2;
  localparam int CHAN_W = 4;
  localparam int VEC_W = GRP_W + CHAN_W;
  localparam int NCHAN = 9;
  localparam int MAX_CHAN = 8;
  localparam logic [GRP_W-1:0] GRP_NONE = 2'b00;
  localparam logic [GRP_W-1:0] GRP_A = 2'b01;
  localparam logic [GRP_W-1:0] GRP_B = 2'b10;
  localparam logic [GRP_W-1:0] GRP_C = 2'b11;
endpackage

// File: rtl/intr_req_qualifier.sv
// intr_req_qualifier: encodes the group flags into a candidate and counts consecutive identical valid samples.
module intr_req_qualifier
  import intr_dispatch_pkg::*;
#(
  parameter int QUAL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pa,
  input  logic             pb,
  input  logic             pc,
  input  logic [CHAN_W-1:0] chan,
  input  logic             clear,
  output logic [VEC_W-1:0] cand,
  output logic             qualified
);
  logic [GRP_W-1:0] grp;
  logic             valid;
  logic [VEC_W-1:0] prev_q, prev_d;
  logic [2:0]       cnt_q, cnt_d;

  always_comb begin
    grp = pa ? GRP_A : pb ? GRP_B : pc ? GRP_C : GRP_NONE;
    cand = {grp, chan};
    valid = (grp != GRP_NONE) && (chan <= CHAN_W'(MAX_CHAN));
    // qualification is judged on the count this edge will store, so capture coincides with reaching it
    cnt_d = (clear || !valid) ? 3'd0 :
            (cand != prev_q) ? 3'd1 :
            (&cnt_q) ? cnt_q : cnt_q + 3'd1;
    prev_d = clear ? '0 : cand;
    qualified = cnt_d >= 3'(QUAL_CYCLES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      cnt_q <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/intr_dispatch.sv
// intr_dispatch: captures a qualified interrupt candidate and runs the irq/ack/eoi handshake with the CPU.
// Defining INTR_DISPATCH_STATS_EN adds saturating dispatch and timeout counters.
module intr_dispatch
  import intr_dispatch_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int QUAL_CYCLES = 2
`ifdef INTR_DISPATCH_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pa,
  input  logic              pb,
  input  logic              pc,
  input  logic [CHAN_W-1:0] chan,
  output logic              irq,
  output logic [VEC_W-1:0]  irq_vec,
  input  logic              ack,
  input  logic              eoi,
  output logic [NCHAN-1:0]  svc_mask,
  output logic              busy,
  output logic              err_timeout
`ifdef INTR_DISPATCH_STATS_EN
  , output logic [STAT_W-1:0] dispatch_cnt
  , output logic [STAT_W-1:0] timeout_cnt
`endif
);
  state_e            state_q, state_d;
  logic              irq_q, irq_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [NCHAN-1:0]  mask_q, mask_d;
  logic              err_q, err_d;
  logic [7:0]        timer_q, timer_d;
  logic [VEC_W-1:0]  cand;
  logic              qualified;
  logic              q_clear;
  logic              tmo;

  intr_req_qualifier #(.QUAL_CYCLES(QUAL_CYCLES)) u_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .pa        (pa),
    .pb        (pb),
    .pc        (pc),
    .chan      (chan),
    .clear     (q_clear),
    .cand      (cand),
    .qualified (qualified)
  );

  assign tmo = (state_q == REQ) && !ack && (timer_q + 8'd1 == 8'(ACK_TIMEOUT));

  always_comb begin
    state_d = state_q;
    irq_d = irq_q;
    vec_d = vec_q;
    mask_d = mask_q;
    err_d = err_q;
    timer_d = timer_q;
    q_clear = 1'b0;
    case (state_q)
      IDLE: if (qualified) begin
        state_d = REQ;
        irq_d = 1'b1;
        vec_d = cand;
        timer_d = '0;
      end
      REQ: if (ack) begin
        state_d = SERVICE;
        irq_d = 1'b0;
        mask_d = NCHAN'(1) << vec_q[CHAN_W-1:0];
        err_d = 1'b0;
      end else begin
        timer_d = timer_q + 8'd1;
        state_d = tmo ? IDLE : REQ;
        irq_d = !tmo;
        err_d = err_q | tmo;
      end
      SERVICE: if (eoi) begin
        state_d = IDLE;
        mask_d = '0;
        q_clear = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      irq_q <= 1'b0;
      vec_q <= '0;
      mask_q <= '0;
      err_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      irq_q <= irq_d;
      vec_q <= vec_d;
      mask_q <= mask_d;
      err_q <= err_d;
      timer_q <= timer_d;
    end
  end

  assign irq = irq_q;
  assign irq_vec = vec_q;
  assign svc_mask = mask_q;
  assign busy = state_q != IDLE;
  assign err_timeout = err_q;

`ifdef INTR_DISPATCH_STATS_EN
  logic [STAT_W-1:0] disp_q, disp_d, tcnt_q, tcnt_d;
  always_comb begin
    disp_d = ((state_q == REQ) && ack && !(&disp_q)) ? disp_q + 1'b1 : disp_q;
    tcnt_d = (tmo && !(&tcnt_q)) ? tcnt_q + 1'b1 : tcnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      tcnt_q <= '0;
    end else begin
      disp_q <= disp_d;
      tcnt_q <= tcnt_d;
    end
  end
  assign dispatch_cnt = disp_q;
  assign timeout_cnt = tcnt_q;
`endif
endmodule

// File: tb/tb_intr_dispatch.sv
// tb_intr_dispatch: directed self-checking bench for intr_dispatch with hand-computed expectations.
module tb_intr_dispatch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pa = 1'b0, pb = 1'b0, pc = 1'b0;
  logic [3:0] chan = 4'd0;
  logic       ack = 1'b0, eoi = 1'b0;
  logic       irq, busy, err_timeout;
  logic [5:0] irq_vec;
  logic [8:0] svc_mask;
  int         n_tests = 0;
  int         n_fail = 0;
`ifdef INTR_DISPATCH_STATS_EN
  logic [3:0] dispatch_cnt, timeout_cnt;
`endif

  intr_dispatch #(
    .ACK_TIMEOUT(16),
    .QUAL_CYCLES(2)
`ifdef INTR_DISPATCH_STATS_EN
    , .STAT_W(4)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pa          (pa),
    .pb          (pb),
    .pc          (pc),
    .chan        (chan),
    .irq         (irq),
    .irq_vec     (irq_vec),
    .ack         (ack),
    .eoi         (eoi),
    .svc_mask    (svc_mask),
    .busy        (busy),
    .err_timeout (err_timeout)
`ifdef INTR_DISPATCH_STATS_EN
    , .dispatch_cnt (dispatch_cnt)
    , .timeout_cnt  (timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic [3:0] ch);
    pa = a; pb = b; pc = c; chan = ch;
  endtask

  task automatic pulse_ack;
    ack = 1'b1; step(1); ack = 1'b0;
  endtask

  task automatic pulse_eoi;
    eoi = 1'b1; step(1); eoi = 1'b0;
  endtask

  initial begin
    int n;
    step(1);
    check("rst_irq", irq, 0);
    check("rst_vec", irq_vec, 0);
    check("rst_mask", svc_mask, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    step(1);

    drive(1, 0, 0, 4'd5);
    step(1);
    check("basic_not_yet", irq, 0);
    step(1);
    check("basic_irq", irq, 1);
    check("basic_vec", irq_vec, 6'b01_0101);
    check("basic_busy", busy, 1);
    drive(0, 0, 0, 4'd0);
    pulse_ack();
    check("basic_ack_irq", irq, 0);
    check("basic_mask", svc_mask, 9'h020);
    check("basic_vec_hold", irq_vec, 6'b01_0101);
    pulse_eoi();
    check("basic_eoi_mask", svc_mask, 0);
    check("basic_eoi_busy", busy, 0);

    ack = 1'b1; eoi = 1'b1;
    step(2);
    ack = 1'b0; eoi = 1'b0;
    check("idle_ackeoi_busy", busy, 0);
    check("idle_ackeoi_mask", svc_mask, 0);

    drive(0, 1, 1, 4'd2);
    step(2);
    check("prio_irq", irq, 1);
    check("prio_vec", irq_vec, 6'b10_0010);
    drive(1, 0, 0, 4'd6);
    step(3);
    check("req_vec_frozen", irq_vec, 6'b10_0010);
    drive(0, 0, 0, 4'd0);
    pulse_ack();
    check("prio_mask", svc_mask, 9'h004);
    pulse_eoi();

    n = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, (i % 2 == 0) ? 4'd2 : 4'd4);
      step(1);
      if (irq) n++;
    end
    check("glitch_never", n, 0);
    drive(1, 0, 0, 4'd12);
    step(6);
    check("invalid_chan_irq", irq, 0);
    check("invalid_chan_busy", busy, 0);
    drive(0, 0, 0, 4'd0);
    step(1);

    drive(1, 0, 0, 4'd1);
    step(2);
    check("tmo_irq_up", irq, 1);
    drive(0, 0, 0, 4'd0);
    n = 0;
    while (irq && n < 40) begin
      step(1);
      n++;
    end
    check("tmo_cycles", n, 16);
    check("tmo_err", err_timeout, 1);
    check("tmo_busy", busy, 0);

    drive(1, 0, 0, 4'd7);
    step(2);
    check("err_sticky", err_timeout, 1);
    drive(0, 0, 0, 4'd0);
    pulse_ack();
    check("err_cleared", err_timeout, 0);
    check("mask_ch7", svc_mask, 9'h080);
    pulse_eoi();

    drive(0, 0, 1, 4'd8);
    step(2);
    drive(0, 0, 0, 4'd0);
    step(15);
    check("coinc_irq_held", irq, 1);
    pulse_ack();
    check("coinc_busy", busy, 1);
    check("coinc_mask", svc_mask, 9'h100);
    check("coinc_err", err_timeout, 0);
    step(3);
    check("svc_no_eoi_hold", svc_mask, 9'h100);
    pulse_eoi();

    drive(1, 0, 0, 4'd3);
    step(2);
    check("mid_req_irq", irq, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_irq", irq, 0);
    check("async_rst_vec", irq_vec, 0);
    check("async_rst_mask", svc_mask, 0);
    check("async_rst_busy", busy, 0);
    drive(0, 0, 0, 4'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

`ifdef INTR_DISPATCH_STATS_EN
    check("stats_rst_disp", dispatch_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 4'(i % 9));
      step(2);
      drive(0, 0, 0, 4'd0);
      pulse_ack();
      pulse_eoi();
    end
    check("stats_disp_sat", dispatch_cnt, 15);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 4'd0);
      step(2);
      drive(0, 0, 0, 4'd0);
      step(16);
    end
    check("stats_tmo", timeout_cnt, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
